// File: rtl/image_tiler_8x10_3x3x4x4.sv
// image_tiler_8x10_3x3x4x4: buffers an 8x10 raster frame and emits it as a 3x3 grid of padded 4x4 tiles.
// Define TILER_PAD_REPLICATE_EN for edge-replicate padding instead of PAD_VALUE.
module image_tiler_8x10_3x3x4x4 #(
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16*DATA_WIDTH-1:0] out_tile,
    output logic [1:0]               out_tile_row,
    output logic [1:0]               out_tile_col,
    output logic                     out_last,
    output logic                     frame_err
);
    typedef enum logic {LOAD, EMIT} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] mem [0:79];
    logic [6:0] cnt;
    logic [3:0] tile, tsel, rr, cc;
    logic [1:0] tr, tc;
    logic [6:0] idx;
    logic [16*DATA_WIDTH-1:0] nxt;

    assign in_ready = (state == LOAD);

    // Next tile to present: tile 0 when entering EMIT, otherwise the successor of the current one.
    always_comb begin
        tsel = (state == EMIT) ? tile + 4'd1 : 4'd0;
        tr = (tsel >= 4'd6) ? 2'd2 : (tsel >= 4'd3) ? 2'd1 : 2'd0;
        tc = 2'(tsel - 4'(tr) * 4'd3);
        nxt = '0;
        rr = '0;
        cc = '0;
        idx = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rr = {tr, 2'(r)};
                cc = {tc, 2'(c)};
`ifdef TILER_PAD_REPLICATE_EN
                rr = (rr > 4'd7) ? 4'd7 : rr;
                cc = (cc > 4'd9) ? 4'd9 : cc;
                idx = 7'(rr) * 7'd10 + 7'(cc);
                nxt[(r*4+c)*DATA_WIDTH +: DATA_WIDTH] = mem[idx];
`else
                idx = 7'(rr) * 7'd10 + 7'(cc);
                nxt[(r*4+c)*DATA_WIDTH +: DATA_WIDTH] = (rr < 4'd8 && cc < 4'd10) ? mem[idx] : PAD_VALUE;
`endif
            end
        end
    end

    always_ff @(posedge clk)
        if (in_valid && in_ready) mem[cnt] <= in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt <= '0;
            tile <= '0;
            out_valid <= 1'b0;
            out_tile <= '0;
            out_tile_row <= '0;
            out_tile_col <= '0;
            out_last <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == LOAD) begin
                if (in_valid) begin
                    frame_err <= in_last != (cnt == 7'd79);
                    cnt <= (cnt == 7'd79) ? 7'd0 : cnt + 7'd1;
                    if (cnt == 7'd79) begin
                        // Tile 0 never touches the element written on this beat, so the buffer is safe to read.
                        state <= EMIT;
                        tile <= '0;
                        out_valid <= 1'b1;
                        out_tile <= nxt;
                        out_tile_row <= tr;
                        out_tile_col <= tc;
                        out_last <= 1'b0;
                    end
                end
            end else if (out_ready) begin
                if (tile == 4'd8) begin
                    state <= LOAD;
                    tile <= '0;
                    out_valid <= 1'b0;
                    out_last <= 1'b0;
                end else begin
                    tile <= tsel;
                    out_tile <= nxt;
                    out_tile_row <= tr;
                    out_tile_col <= tc;
                    out_last <= (tile == 4'd7);
                end
            end
        end
    end
endmodule

// File: doc/image_tiler_8x10_3x3x4x4.md
Name: image_tiler_8x10_3x3x4x4

Overview:
- Splits an 8x10 image into a 3x3 grid of 4x4 tiles. This is the inverse of the winograd tile-stitch stage, which places tiles at stride 4 and clips.
- Input: image elements streamed one per beat in raster order over a valid/ready handshake.
- Output: one complete 4x4 tile per beat, in tile-row-major order, with tile coordinates.
- Tile regions beyond the image (rows 8-11, cols 10-11) are padded.
- Sits between the matrix buffer reader and the winograd input-transform stage.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- PAD_VALUE, 16'h0000, value used for out-of-image tile positions (zero-pad mode).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element.
- in_data  input  DATA_WIDTH  image element, raster order (row 0 col 0..9, then row 1, ...).
- in_last  input  1  asserted by the source on the 80th element.
- out_valid  output  1  out_tile is valid.
- out_ready  input  1  downstream accepts the tile.
- out_tile  output  16*DATA_WIDTH  flattened tile; element (r,c) at bits [((r*4+c)*DATA_WIDTH) +: DATA_WIDTH].
- out_tile_row  output  2  tile row index tr, 0..2.
- out_tile_col  output  2  tile column index tc, 0..2.
- out_last  output  1  high with the tile (2,2).
- frame_err  output  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Reset values:
  - in_ready=1 (enters LOAD), out_valid=0, out_tile=0, out_tile_row=0, out_tile_col=0, out_last=0, frame_err=0.
  - Element counter=0, tile counter=0.
  - Buffer contents are don't-care.
- Internal storage: 80 x DATA_WIDTH register buffer; 7-bit element counter 0..79; 4-bit tile counter 0..8.
- State LOAD:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready beat writes buffer[row][col], with row = count/10 and col = count%10, then increments the counter.
  - When the beat with count==79 is accepted: counter clears, state goes to EMIT, out_valid=1 on the next cycle (latency 1 cycle from the last accepted element).
- State EMIT:
  - in_ready=0.
  - Current tile t: tr = t/3, tc = t%3.
  - out_tile element (r,c) = buffer[tr*4+r][tc*4+c] when tr*4+r<8 and tc*4+c<10; otherwise the pad value.
  - Outputs are registered and held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: t increments and the next tile is presented on the next cycle.
  - When tile 8 is accepted: out_valid falls, state returns to LOAD, in_ready=1 on the next cycle.
- Tile properties:
  - Tiles (2,x) are entirely padding.
  - Tiles (x,2) have cols 2..3 padded.
- frame_err checks:
  - Pulses for one cycle if in_last=1 on an accepted beat with count!=79.
  - Pulses for one cycle if in_last=0 on the accepted beat with count==79.
  - The frame always completes on count, regardless of in_last.
- Sustained backpressure: out_ready=0 stalls indefinitely with no data loss.
- in_valid during EMIT: ignored (in_ready=0).
- Reset mid-operation: in any state, rst returns the block to the reset values next cycle. The partial frame and pending tiles are discarded.
- Back-to-back frames: at most one bubble cycle between the last tile accept and the first element accept of the next frame.

Optional Feature:
- Macro: TILER_PAD_REPLICATE_EN.
- Defined: out-of-image positions take the value of the nearest in-image element, buffer[min(row,7)][min(col,9)] (edge replicate). PAD_VALUE is unused.
- Undefined: out-of-image positions take PAD_VALUE.
- Handshake and timing are identical in both builds.

Test Plan:
- Load pattern, no stall: load image with pixel = {row[3:0],col[3:0]} (e.g. [7][9]=0x79) with in_valid held high, out_ready=1.
  - Tile (0,0): element(0,0)=0x00, element(3,3)=0x33.
  - Tile (1,1): element(0,0)=0x44.
  - out_valid rises exactly 1 cycle after the 80th accept.
  - 9 tiles on consecutive cycles; out_last only on (2,2).
- Padding, zero mode:
  - Tile (0,2): element(1,1)=0x19, element(1,2)=0x0000.
  - Tile (2,0): all 16 elements 0x0000.
  - With PAD_VALUE=16'hFFFF the same positions read 0xFFFF.
- Backpressure: hold out_ready=0 for 5 cycles on tile 4 and toggle it randomly for the rest → tile 4 data and indices stay stable, no tile is skipped or duplicated, in_ready stays 0 until the tile 8 accept.
- Frame check: assert in_last on element 40 → frame_err pulses once; the frame still completes at 80 elements and tile contents are correct.
- Reset mid-operation:
  - rst after 37 elements → next cycle in_ready=1, out_valid=0; a fresh 80-element frame produces correct tiles.
  - rst during EMIT at tile 3 → same recovery.
- Replicate build (TILER_PAD_REPLICATE_EN defined):
  - Tile (0,2): element(1,2)=0x19.
  - Tile (2,0): element(0,0)=0x70.
  - Tile (2,2): element(3,3)=0x79.
